// File: rtl/sobel_pkg.sv
// rtl/sobel_pkg.sv - shared state encoding and gradient width offset for the sobel stream filter
package sobel_pkg;

   typedef enum logic [1:0] {
      FILL  = 2'd0,
      RUN   = 2'd1,
      FLUSH = 2'd2
   } state_t;

   // Gradients carry three extra bits over the pixel width: a 1-2-1 kernel
   // side sums to at most 4x a pixel, plus one sign bit.
   localparam int GRAD_EXTRA_W = 3;

endpackage

// File: rtl/sobel_line_buffer.sv
// rtl/sobel_line_buffer.sv - two row memories plus a 3x3 window of pixel columns
module sobel_line_buffer
   import sobel_pkg::*;
#(
   parameter int WIDTH_P   = 640,
   parameter int PIXEL_W_P = 8,
   parameter int COL_W_P   = $clog2(WIDTH_P)
) (
   input  logic                        clk_i,
   input  logic                        reset_ni,
   input  logic                        shift_i,
   input  logic [COL_W_P-1:0]          col_i,
   input  logic [PIXEL_W_P-1:0]        pixel_i,
   output logic [2:0][PIXEL_W_P-1:0]   left_o,
   output logic [2:0][PIXEL_W_P-1:0]   right_o,
   output logic [PIXEL_W_P-1:0]        top_o,
   output logic [PIXEL_W_P-1:0]        bottom_o
);

   // row_prev holds the row above the incoming pixel, row_prev2 the one above that.
   logic [PIXEL_W_P-1:0] row_prev  [WIDTH_P];
   logic [PIXEL_W_P-1:0] row_prev2 [WIDTH_P];

   // Columns are packed top (index 0) to bottom (index 2).
   logic [2:0][PIXEL_W_P-1:0] col_new;
   logic [2:0][PIXEL_W_P-1:0] col_c;
   logic [2:0][PIXEL_W_P-1:0] col_l;

   assign col_new = {pixel_i, row_prev[col_i], row_prev2[col_i]};

   // Push the accepted pixel into the row memories, aging the previous row down one line.
   always_ff @(posedge clk_i) begin
      if (shift_i) begin
         row_prev[col_i]  <= pixel_i;
         row_prev2[col_i] <= row_prev[col_i];
      end
   end

   // Slide the window one column to the right on every accepted pixel.
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         col_l <= '0;
         col_c <= '0;
      end else if (shift_i) begin
         col_l <= col_c;
         col_c <= col_new;
      end
   end

   // The right column is the live one being accepted this cycle.
   assign left_o   = col_l;
   assign right_o  = col_new;
   assign top_o    = col_c[0];
   assign bottom_o = col_c[2];

endmodule

// File: rtl/sobel_stream_filter.sv
// rtl/sobel_stream_filter.sv - streaming 3x3 sobel magnitude filter; SOBEL_THRESHOLD_EN adds a binary threshold
module sobel_stream_filter
   import sobel_pkg::*;
#(
   parameter int WIDTH_P   = 640,
   parameter int HEIGHT_P  = 480,
   parameter int PIXEL_W_P = 8
) (
   input  logic                  clk_i,
   input  logic                  reset_ni,
   input  logic                  valid_i,
   output logic                  ready_o,
   input  logic [PIXEL_W_P-1:0]  pixel_i,
   output logic                  valid_o,
   input  logic                  ready_i,
   output logic [PIXEL_W_P-1:0]  pixel_o,
   output logic                  last_o
`ifdef SOBEL_THRESHOLD_EN
   ,
   input  logic [PIXEL_W_P-1:0]  threshold_i
`endif
);

   localparam int COL_W  = $clog2(WIDTH_P);
   localparam int ROW_W  = $clog2(HEIGHT_P);
   localparam int GRAD_W = PIXEL_W_P + GRAD_EXTRA_W;
   localparam logic [GRAD_W-1:0] SAT_MAX = {{GRAD_EXTRA_W{1'b0}}, {PIXEL_W_P{1'b1}}};

   state_t             state;
   logic               active;
   logic [ROW_W-1:0]   in_row;
   logic [COL_W-1:0]   in_col;
   logic [ROW_W-1:0]   out_row;
   logic [COL_W-1:0]   out_col;

   logic in_fire;
   logic out_fire;
   logic in_last;
   logic out_last;
   logic load;
   logic border;

   logic [2:0][PIXEL_W_P-1:0] left;
   logic [2:0][PIXEL_W_P-1:0] right;
   logic [PIXEL_W_P-1:0]      top;
   logic [PIXEL_W_P-1:0]      bottom;

   logic signed [GRAD_W-1:0] gx;
   logic signed [GRAD_W-1:0] gy;
   logic [GRAD_W-1:0]        ax;
   logic [GRAD_W-1:0]        ay;
   logic [GRAD_W-1:0]        mag;
   logic [PIXEL_W_P-1:0]     mag_sat;
   logic [PIXEL_W_P-1:0]     filt;
   logic [PIXEL_W_P-1:0]     result;

   function automatic logic signed [GRAD_W-1:0] ext(input logic [PIXEL_W_P-1:0] p);
      return signed'({{GRAD_EXTRA_W{1'b0}}, p});
   endfunction

   sobel_line_buffer #(
      .WIDTH_P   (WIDTH_P),
      .PIXEL_W_P (PIXEL_W_P),
      .COL_W_P   (COL_W)
   ) u_line_buffer (
      .clk_i    (clk_i),
      .reset_ni (reset_ni),
      .shift_i  (in_fire),
      .col_i    (in_col),
      .pixel_i  (pixel_i),
      .left_o   (left),
      .right_o  (right),
      .top_o    (top),
      .bottom_o (bottom)
   );

   assign in_fire  = valid_i && ready_o;
   assign out_fire = valid_o && ready_i;
   assign in_last  = (in_row == ROW_W'(HEIGHT_P - 1)) && (in_col == COL_W'(WIDTH_P - 1));
   assign out_last = (out_row == ROW_W'(HEIGHT_P - 1)) && (out_col == COL_W'(WIDTH_P - 1));

   // A new result enters the output register on each accepted pixel while running,
   // and during flush whenever the register is free, until the frame's last pixel is held.
   assign load = ((state == RUN) && in_fire) ||
                 ((state == FLUSH) && !(valid_o && last_o) && (!valid_o || ready_i));

   assign border = (out_row == '0) || (out_row == ROW_W'(HEIGHT_P - 1)) ||
                   (out_col == '0) || (out_col == COL_W'(WIDTH_P - 1));

   // Upstream handshake: open in fill, follow output-register space in run, closed in flush.
   always_comb begin
      ready_o = 1'b0;
      if (active) begin
         case (state)
            FILL:    ready_o = 1'b1;
            RUN:     ready_o = !valid_o || ready_i;
            default: ready_o = 1'b0;
         endcase
      end
   end

   // Gradients and saturated magnitude for the window centred on the next output pixel.
   always_comb begin
      gx = (ext(right[0]) + (ext(right[1]) <<< 1) + ext(right[2])) -
           (ext(left[0])  + (ext(left[1])  <<< 1) + ext(left[2]));
      gy = (ext(left[2]) + (ext(bottom) <<< 1) + ext(right[2])) -
           (ext(left[0]) + (ext(top)    <<< 1) + ext(right[0]));
      ax = gx[GRAD_W-1] ? -gx : gx;
      ay = gy[GRAD_W-1] ? -gy : gy;
      mag = ax + ay;
      mag_sat = (mag > SAT_MAX) ? '1 : mag[PIXEL_W_P-1:0];
`ifdef SOBEL_THRESHOLD_EN
      filt = (mag_sat >= threshold_i) ? '1 : '0;
`else
      filt = mag_sat;
`endif
      result = border ? '0 : filt;
   end

   // Frame sequencing, raster counters and the output register.
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state   <= FILL;
         active  <= 1'b0;
         in_row  <= '0;
         in_col  <= '0;
         out_row <= '0;
         out_col <= '0;
         valid_o <= 1'b0;
         last_o  <= 1'b0;
         pixel_o <= '0;
      end else begin
         active <= 1'b1;

         if (in_fire) begin
            if (in_col == COL_W'(WIDTH_P - 1)) begin
               in_col <= '0;
               in_row <= in_last ? '0 : in_row + ROW_W'(1);
            end else begin
               in_col <= in_col + COL_W'(1);
            end
         end

         if (load) begin
            valid_o <= 1'b1;
            pixel_o <= result;
            last_o  <= out_last;
            if (out_col == COL_W'(WIDTH_P - 1)) begin
               out_col <= '0;
               out_row <= out_last ? '0 : out_row + ROW_W'(1);
            end else begin
               out_col <= out_col + COL_W'(1);
            end
         end else if (out_fire) begin
            valid_o <= 1'b0;
            last_o  <= 1'b0;
         end

         case (state)
            FILL: begin
               if (in_fire && (in_row == ROW_W'(1)) && (in_col == '0)) begin
                  state <= RUN;
               end
            end
            RUN: begin
               if (in_fire && in_last) begin
                  state <= FLUSH;
               end
            end
            FLUSH: begin
               if (out_fire && last_o) begin
                  state <= FILL;
               end
            end
            default: state <= FILL;
         endcase
      end
   end

endmodule

// File: doc/sobel_stream_filter.md
SOBEL_STREAM_FILTER -- requirements
Module: sobel_stream_filter

Interface
REQ-001 SHALL have parameter WIDTH_P, default 640, frame width in pixels (>=3).
REQ-002 SHALL have parameter HEIGHT_P, default 480, frame height in pixels (>=3).
REQ-003 SHALL have parameter PIXEL_W_P, default 8, pixel bit width (input and output).
REQ-004 SHALL have port clk_i  input  1  sole clock, all state on rising edge.
REQ-005 SHALL have port reset_ni  input  1  asynchronous active-low reset.
REQ-006 SHALL have port valid_i  input  1  input pixel valid.
REQ-007 SHALL have port ready_o  output  1  block accepts pixel_i this cycle.
REQ-008 SHALL have port pixel_i  input  PIXEL_W_P  raster-order input pixel.
REQ-009 SHALL have port valid_o  output  1  output pixel valid.
REQ-010 SHALL have port ready_i  input  1  downstream accepts pixel_o.
REQ-011 SHALL have port pixel_o  output  PIXEL_W_P  filtered pixel, raster order.
REQ-012 SHALL have port last_o  output  1  high with final output pixel of a frame.

Function
REQ-013 Input transfer SHALL occur when valid_i && ready_o; output transfer when valid_o && ready_i.
REQ-014 Each frame: exactly WIDTH_P*HEIGHT_P inputs in, exactly WIDTH_P*HEIGHT_P outputs out, raster order.
REQ-015 Interior output (r,c): Gx=[-1 0 1;-2 0 2;-1 0 1], Gy=transpose; gradients signed PIXEL_W_P+3 bits; magnitude |Gx|+|Gy| unsigned PIXEL_W_P+3 bits, saturated to 2^PIXEL_W_P-1.
REQ-016 Border outputs (row 0, row HEIGHT_P-1, col 0, col WIDTH_P-1) SHALL be 0; no wrap between rows.
REQ-017 FSM states FILL, RUN, FLUSH; reset enters FILL.
REQ-018 FILL: ready_o=1, no output; after WIDTH_P+1 accepted inputs -> RUN.
REQ-019 RUN: output k becomes valid the cycle after input k+WIDTH_P+1 is accepted; after final frame input accepted -> FLUSH.
REQ-020 FLUSH: ready_o=0; remaining WIDTH_P+1 outputs emitted at one per accepted transfer; after last_o transfer -> FILL.
REQ-021 Output register SHALL hold pixel_o/valid_o/last_o stable while valid_o && !ready_i; in RUN ready_o = !valid_o || ready_i.
REQ-022 ready_o SHALL NOT depend combinationally on valid_i.
REQ-023 Input/output row and column counters SHALL wrap at WIDTH_P/HEIGHT_P; back-to-back frames SHALL need no idle cycle other than FLUSH.

Reset
REQ-024 reset_ni low SHALL asynchronously force FILL, valid_o=0, last_o=0, pixel_o=0, ready_o=0, all counters 0.
REQ-025 ready_o SHALL rise the first cycle after reset_ni deasserts; reset mid-frame discards the partial frame, next input is pixel (0,0).
REQ-026 Line-buffer contents need not be reset; counters make stale data unobservable.

Configuration
REQ-027 Macro SOBEL_THRESHOLD_EN defined: extra port threshold_i input PIXEL_W_P; pixel_o = all-ones if saturated magnitude >= threshold_i else 0 (borders still 0).
REQ-028 Macro undefined: no threshold_i port; pixel_o = saturated magnitude.

Structure
REQ-029 Package sobel_pkg SHALL hold the FSM state enum and the gradient-width constant offset (+3).
REQ-030 Sub-module sobel_line_buffer SHALL store two WIDTH_P-deep rows and present the 3x3 window columns.

Verification
REQ-031 Reset: reset_ni=0 mid-frame -> valid_o=0, pixel_o=0, last_o=0 immediately; restart frame produces 640*480 outputs.
REQ-032 Constant image 0x80 -> all 307200 outputs 0, last_o only on output 307199.
REQ-033 Step image cols 0..319=0, 320..639=10 -> interior cols 319,320 = 40, all else 0.
REQ-034 Step 0/100 -> cols 319,320 = 255 (saturated); with SOBEL_THRESHOLD_EN, threshold_i=200 -> 255, threshold_i=0x00 on flat region -> 255, borders 0.
REQ-035 ready_i random 50% toggle, valid_i random gaps -> output stream identical to no-backpressure run; pixel_o stable while stalled.
REQ-036 Two back-to-back frames, WIDTH_P=8 HEIGHT_P=4 -> 32 outputs each, first output of frame 2 follows 9 accepted inputs of frame 2.
